// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: {bout,diff} = a - b - bin, one bit per clock, LSB first.
// Define SERIAL_SUB_OVERFLOW_EN to add the signed-overflow output ovf.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_n;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             borrow;
  logic [CW-1:0]    count;
  logic             d;
  logic             nb;
  logic             last;

  assign d    = a_sr[0] ^ b_sr[0] ^ borrow;
  assign nb   = (~a_sr[0] & b_sr[0]) |
                (~(a_sr[0] ^ b_sr[0]) & borrow);
  assign last = (count == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_n = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last) state_n = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef SERIAL_SUB_OVERFLOW_EN
  // Operand sign bits, kept because the shift registers lose them.
  logic [1:0] msb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msb <= '0;
      ovf <= 1'b0;
    end else if (state == IDLE && start) begin
      msb <= {a[WIDTH-1], b[WIDTH-1]};
    end else if (state == SHIFT && last) begin
      ovf <= (msb[1] != msb[0]) && (d != msb[1]);
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      borrow <= 1'b0;
      count  <= '0;
      diff   <= '0;
      bout   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            borrow <= bin;
            count  <= '0;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          diff   <= {d, diff[WIDTH-1:1]};
          borrow <= nb;
          count  <= count + CW'(1);
          if (last) bout <= nb;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and exhaustive checks of serial_subtractor at WIDTH=4.
// Overflow cases run when SERIAL_SUB_OVERFLOW_EN is defined.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Waits for IDLE, pulses start, returns {bout,diff}, cycles to done
  // and whether busy stayed high from the accept edge to done.
  task automatic do_op(input logic [W-1:0] av,
                       input logic [W-1:0] bv,
                       input logic bv_in,
                       output logic [W:0] res,
                       output int lat,
                       output logic busy_ok);
    int guard = 0;
    @(negedge clk);
    while (busy && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    a = av; b = bv; bin = bv_in; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_ok = busy;
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      busy_ok = busy_ok & busy;
    end
    if (!done) check("timeout", 0, 1);
    res = {bout, diff};
  endtask

  initial begin
    logic [W:0] res;
    logic       bok;
    logic [4:0] exp;
    int         lat;
    int         gap;
    bit         seen;

    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 0);
    @(negedge clk); rst = 1'b0;

    do_op(4'd9, 4'd3, 1'b0, res, lat, bok);
    check("9-3", res, 5'd6);
    check("9-3_lat", lat, W);
    check("9-3_busy", bok, 1);
    @(posedge clk); #1;
    check("9-3_done_len", done, 0);
    check("9-3_busy_end", busy, 0);
    check("9-3_hold", {bout, diff}, 5'd6);

    do_op(4'd3, 4'd9, 1'b0, res, lat, bok);
    check("3-9", res, 5'd26);
    do_op(4'd0, 4'd0, 1'b1, res, lat, bok);
    check("0-0-1", res, 5'd31);
    do_op(4'd15, 4'd0, 1'b0, res, lat, bok);
    check("15-0", res, 5'd15);
    do_op(4'd7, 4'd7, 1'b0, res, lat, bok);
    check("7-7", res, 5'd0);

    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        for (int k = 0; k < 2; k++) begin
          do_op(W'(i), W'(j), k[0], res, lat, bok);
          exp = 5'(i - j - k);
          if (res !== exp)
            $display("  operands a=%0d b=%0d bin=%0d", i, j, k);
          check("exh", res, exp);
        end

    // start held high, operands disturbed during SHIFT
    @(negedge clk);
    while (busy) @(negedge clk);
    a = 4'd5; b = 4'd2; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 4'd1; b = 4'd1;
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check("held_lat", lat, W);
    check("held_res1", {bout, diff}, 5'd3);
    a = 4'd12; b = 4'd4;
    gap = 0;
    @(posedge clk); #1;
    check("held_busy_idle", busy, 0);
    while (!done && gap < 20) begin
      @(posedge clk); #1; gap++;
    end
    check("held_gap", gap + 1, W + 2);
    check("held_res2", {bout, diff}, 5'd8);
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("held_stop", busy, 0);

    // asynchronous reset in the middle of SHIFT
    @(negedge clk);
    a = 4'd9; b = 4'd3; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_res", {bout, diff}, 5'd0);
    @(negedge clk); rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1;
    end
    check("arst_nodone", seen, 0);
    do_op(4'd5, 4'd2, 1'b0, res, lat, bok);
    check("arst_5-2", res, 5'd3);

`ifdef SERIAL_SUB_OVERFLOW_EN
    do_op(4'd8, 4'd1, 1'b0, res, lat, bok);
    check("ovf_8-1", {ovf, res}, {1'b1, 5'd7});
    do_op(4'd7, 4'd15, 1'b0, res, lat, bok);
    check("ovf_7-15", {ovf, res[W-1:0]}, {1'b1, 4'd8});
    do_op(4'd5, 4'd3, 1'b0, res, lat, bok);
    check("ovf_5-3", {ovf, res}, {1'b0, 5'd2});
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, multi-cycle subtractor: computes diff = a - b - bin over WIDTH clock cycles, one bit per cycle, using a single registered borrow.
- Inverse-direction companion to the team's combinational ripple adder; shares its operand/carry conventions: bin in, bout out, and {bout,diff} forms the WIDTH+1-bit result.
- Used where area matters more than latency. Start/done handshake toward a sequencing controller.

Parameters:
- WIDTH, 4, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on accepted start.
- b  input  WIDTH  subtrahend; captured on accepted start.
- bin  input  1  borrow in; captured on accepted start.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse; diff/bout valid.
- diff  output  WIDTH  difference, LSB-first shift result.
- bout  output  1  borrow out; 1 when a < b + bin (unsigned).

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, diff=0, bout=0, internal shift registers, bit counter and borrow cleared. Reset may assert mid-operation; the operation is discarded with no done pulse.
- States: IDLE, SHIFT, DONE.
- IDLE: on edge with start=1, latch a, b into shift regs, borrow<=bin, count<=0, go SHIFT. start=0 stays IDLE.
- SHIFT, each edge:
  - d = a_sr[0] ^ b_sr[0] ^ borrow.
  - borrow <= (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow).
  - a_sr, b_sr shift right.
  - diff shifts right with d entering the MSB.
  - count++.
  - On the edge processing bit WIDTH-1: go DONE, done<=1, bout<=next borrow.
- DONE: lasts exactly one cycle; next edge goes to IDLE, done<=0.
- Latency: start accepted at edge k; done high during the cycle following edge k+WIDTH. Max throughput is one op per WIDTH+2 cycles.
- start while busy (SHIFT or DONE) is ignored, not queued. Inputs a/b/bin may change freely after acceptance.
- diff and bout are meaningful only when done=1 or in IDLE after done. In IDLE they hold the last result until the next accepted start.
- Arithmetic is unsigned modulo 2^WIDTH. {bout,diff} equals (a - b - bin) mod 2^(WIDTH+1), i.e. two's-complement WIDTH+1-bit result.
- Boundaries:
  - 0 - 0 - 1: diff all-ones, bout=1.
  - (2^WIDTH-1) - 0 - 0: diff all-ones, bout=0.
  - a == b with bin=0: diff=0, bout=0.
- Counter width is clog2(WIDTH)+1; no wrap within an operation.

Optional Feature:
- Macro: SERIAL_SUB_OVERFLOW_EN.
- Defined: adds output port ovf (1 bit, reset 0).
  - ovf is updated together with bout at the end of SHIFT.
  - ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]), i.e. signed two's-complement overflow of a - b - bin. Operand MSBs are retained in a dedicated register.
  - ovf holds alongside diff.
- Undefined: port ovf and its logic absent; all other behaviour identical.

Test Plan:
- WIDTH=4, a=9, b=3, bin=0, one-cycle start pulse -> done exactly 4 cycles after accept edge, diff=6, bout=0; busy high from accept edge until DONE ends.
- a=3, b=9, bin=0 -> diff=10, bout=1; then a=0, b=0, bin=1 -> diff=15, bout=1.
- Exhaustive: all 16x16x2 combinations back-to-back, each checked as {bout,diff} === (a-b-bin) mod 32. 512 checks, zero errors.
- start held high continuously, and a/b changed during SHIFT -> operations accepted only from IDLE (every WIDTH+2 cycles); results reflect operands latched at acceptance.
- rst pulsed asynchronously mid-SHIFT (between edges) -> busy, done, diff, bout go 0 immediately; no done pulse; next start computes 5-2-0 = 3 correctly.
- With SERIAL_SUB_OVERFLOW_EN:
  - a=8, b=1, bin=0 -> diff=7, ovf=1.
  - a=7, b=15, bin=0 -> diff=8, ovf=1.
  - a=5, b=3 -> diff=2, ovf=0.
